memory_load_unit: RTL and testbench
===================================

# memory_load_unit

Load-side counterpart of the store request helper: accepts one load at a time from the memory stage, issues it on the data bus, waits for the response, then extracts, aligns and sign/zero-extends the addressed bytes into a 64-bit result. It sits between the memory pipeline stage and the dbus port, next to the store path. It owns the request/response handshake for loads and holds each result until the pipeline takes it.

## Interface
Parameters: none. All widths come from `common`.

Ports (name, direction, width, meaning):
- `clk` input 1: clock.
- `reset` input 1: asynchronous, active-low reset.
- `req_valid` input 1: a load request is present.
- `req_ready` output 1: the unit can accept a request (IDLE only).
- `req_addr` input 64: byte address of the load.
- `req_mode` input 4: load mode. 0000 lb, 0001 lh, 0010 lw, 0011 ld, 0100 lbu, 0101 lhu, 0110 lwu. All other values are unsupported.
- `dreq_valid` output 1: data bus request valid.
- `dreq_addr` output 64: bus address, `{addr[63:3],3'b000}`.
- `dreq_size` output 3 (`msize_t`): bus access size.
- `dreq_strobe` output 8: always 0 (read).
- `dresp_addr_ok` input 1: bus accepted the address.
- `dresp_data_ok` input 1: bus data valid.
- `dresp_data` input 64: bus read data.
- `out_valid` output 1: result available.
- `out_data` output 64: extended load result.
- `out_ready` input 1: consumer takes the result.
- `out_fault` output 1: misaligned load. Present only with `MEMORY_LOAD_MISALIGN_CHECK_EN`.

## Operation
- FSM states: IDLE, WAIT, RESP. Reset state is IDLE.
- **IDLE.** `req_ready`=1. When `req_valid` is high, capture the address and mode.
  - Supported mode, aligned: go to WAIT.
  - Unsupported mode: go to RESP with the result forced to 0. No bus access.
- **WAIT.** `dreq_valid`=1, and the bus address, size and strobe are stable.
  - `dreq_valid` is held until `dresp_data_ok`. `dresp_addr_ok` alone changes nothing.
  - `addr_ok` and `data_ok` may arrive in the same cycle.
  - On `dresp_data_ok`: register the extracted result and go to RESP.
- **RESP.** `out_valid`=1 and `out_data` is stable.
  - On `out_ready`: go to IDLE.
  - No new request is accepted in the same cycle (no bypass).
- Size mapping: lb and lbu use MSIZE1; lh and lhu use MSIZE2; lw and lwu use MSIZE4; ld uses MSIZE8.
- Extraction rules:
  - Byte offset `off = addr[2:0]`. Shift `dresp_data` right by 8×off.
  - Take the low 8, 16, 32 or 64 bits.
  - Sign-extend for lb, lh and lw. Zero-extend for lbu, lhu and lwu.
- Reset values: `req_ready`=0 while reset is asserted, then 1 in IDLE. `dreq_valid`=0. `out_valid`=0. `out_data`=0. `out_fault`=0. `dreq_addr`=0.
- Reset asserted mid-transaction: all outputs drop asynchronously to their reset values and the in-flight bus response is discarded. A late `data_ok` arriving in IDLE is ignored.

## Timing
- Request accepted at cycle 0. `dreq_valid` is high from cycle 1.
- `dresp_data_ok` at cycle N gives `out_valid` at cycle N+1.
- Minimum request-to-result latency: 2 cycles.
- The unsupported-mode path, and the fault path when it is compiled in, yield `out_valid` at cycle 1.
- Throughput: one load per ≥3 cycles.
- Outputs are registered, except `req_ready`, which is decoded from the state.

## Configuration
- `MEMORY_LOAD_MISALIGN_CHECK_EN` defined:
  - In IDLE, an lh or lhu with addr[0]≠0, an lw or lwu with addr[1:0]≠0, or an ld with addr[2:0]≠0 goes directly to RESP with `out_fault`=1 and `out_data`=0. No bus request is issued.
  - `out_fault` is 0 for every other result.
- Macro undefined:
  - The `out_fault` port is absent.
  - Misaligned loads are issued as-is. Bytes shifted past bit 63 read as zero before extension.

## Structure
- Shared package `common` holds:
  - a `load_mode_t` enum with the encodings above;
  - a `load_msize(load_mode_t)` function;
  - `msize_t` and the MSIZE constants, which already exist there.
- Sub-module `load_align_extend`: combinational function of (data, offset, mode) to the 64-bit result. It is reused by the future cache hit path.
- Top level: the FSM plus the capture registers.

## Test plan
- Setup for the first four scenarios: `dresp_data`=0xF0E0D0C0B0A09080.
- lb at 0x1003 → `dreq_addr`=0x1000, `dreq_size`=MSIZE1, `out_data`=0xFFFFFFFFFFFFFFB0. lbu at the same address → 0x00000000000000B0.
- lh at 0x1006 → 0xFFFFFFFFFFFFF0E0. lhu → 0xF0E0.
- lwu at 0x1004 → 0x00000000F0E0D0C0. lw at 0x1000 → 0xFFFFFFFFB0A09080. ld at 0x1000 → the full word, with `dreq_size`=MSIZE8.
- Bus stall: `data_ok` is held off 5 cycles after `addr_ok` → `dreq_valid` stays high and stable throughout. `out_valid` rises exactly 1 cycle after `data_ok`.
- Backpressure and reset:
  - `out_ready`=0 for 3 cycles → `out_valid`/`out_data` hold and `req_ready`=0. Then `out_ready` for 1 cycle → IDLE.
  - `reset` asserted during WAIT → `dreq_valid` is 0 immediately. A subsequent `data_ok` produces no `out_valid`.
- With the macro defined: lh at 0x1001 → `out_fault`=1 and `out_data`=0 at cycle 1, and `dreq_valid` never rises. Mode 0111 → `out_data`=0 and `out_fault`=0, with no bus access.

Source files
------------

// File: rtl/common_pkg.sv
// rtl/common_pkg.sv - shared memory-access types: bus sizes, load modes, load helpers
package common;

  typedef enum logic [2:0] {
    MSIZE1 = 3'd0,
    MSIZE2 = 3'd1,
    MSIZE4 = 3'd2,
    MSIZE8 = 3'd3
  } msize_t;

  typedef enum logic [3:0] {
    LD_LB  = 4'b0000,
    LD_LH  = 4'b0001,
    LD_LW  = 4'b0010,
    LD_LD  = 4'b0011,
    LD_LBU = 4'b0100,
    LD_LHU = 4'b0101,
    LD_LWU = 4'b0110
  } load_mode_t;

  // Bus access size for each load mode.
  function automatic msize_t load_msize(input load_mode_t mode);
    case (mode)
      LD_LB, LD_LBU: return MSIZE1;
      LD_LH, LD_LHU: return MSIZE2;
      LD_LW, LD_LWU: return MSIZE4;
      default:       return MSIZE8;
    endcase
  endfunction

  // Encodings above 0110 have no load meaning.
  function automatic logic load_mode_supported(input logic [3:0] mode);
    return (mode <= 4'b0110);
  endfunction

  // Natural-alignment check for a supported load mode at a given byte offset.
  function automatic logic load_misaligned(input load_mode_t mode, input logic [2:0] off);
    case (mode)
      LD_LH, LD_LHU: return (off[0] != 1'b0);
      LD_LW, LD_LWU: return (off[1:0] != 2'b00);
      LD_LD:         return (off != 3'b000);
      default:       return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/load_align_extend.sv
// rtl/load_align_extend.sv - byte extraction, alignment and sign/zero extension of a 64-bit bus word
module load_align_extend
  import common::*;
(
  input  logic [63:0] data,
  input  logic [2:0]  offset,
  input  logic [3:0]  mode,
  output logic [63:0] result
);

  logic [63:0] shifted;

  // Bytes shifted past bit 63 come in as zero, so misaligned loads see zero upper bytes.
  always_comb begin
    shifted = data >> {offset, 3'b000};
    case (load_mode_t'(mode))
      LD_LB:   result = {{56{shifted[7]}},  shifted[7:0]};
      LD_LH:   result = {{48{shifted[15]}}, shifted[15:0]};
      LD_LW:   result = {{32{shifted[31]}}, shifted[31:0]};
      LD_LD:   result = shifted;
      LD_LBU:  result = {56'd0, shifted[7:0]};
      LD_LHU:  result = {48'd0, shifted[15:0]};
      LD_LWU:  result = {32'd0, shifted[31:0]};
      default: result = 64'd0;
    endcase
  end

endmodule

// File: rtl/memory_load_unit.sv
// rtl/memory_load_unit.sv - single-outstanding load FSM between memory stage and dbus; optional MEMORY_LOAD_MISALIGN_CHECK_EN
module memory_load_unit
  import common::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [63:0] req_addr,
  input  logic [3:0]  req_mode,
  output logic        dreq_valid,
  output logic [63:0] dreq_addr,
  output msize_t      dreq_size,
  output logic [7:0]  dreq_strobe,
  input  logic        dresp_addr_ok,
  input  logic        dresp_data_ok,
  input  logic [63:0] dresp_data,
  output logic        out_valid,
  output logic [63:0] out_data,
`ifdef MEMORY_LOAD_MISALIGN_CHECK_EN
  output logic        out_fault,
`endif
  input  logic        out_ready
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state, state_next;
  logic [3:0]  mode_q;
  logic [2:0]  off_q;
  logic        req_supported;
  logic        req_fault;
  logic [63:0] extracted;

  assign req_supported = load_mode_supported(req_mode);
`ifdef MEMORY_LOAD_MISALIGN_CHECK_EN
  assign req_fault = req_supported && load_misaligned(load_mode_t'(req_mode), req_addr[2:0]);
`else
  assign req_fault = 1'b0;
`endif

  assign req_ready   = reset && (state == IDLE);
  assign dreq_strobe = 8'd0;

  load_align_extend u_align (
    .data   (dresp_data),
    .offset (off_q),
    .mode   (mode_q),
    .result (extracted)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state: unsupported or faulting requests skip the bus and go straight to RESP.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (req_valid) state_next = (req_supported && !req_fault) ? WAIT : RESP;
      WAIT: if (dresp_data_ok) state_next = RESP;
      RESP: if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Capture request, hold bus fields through WAIT, register result on data_ok.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mode_q     <= 4'd0;
      off_q      <= 3'd0;
      dreq_addr  <= 64'd0;
      dreq_size  <= MSIZE1;
      dreq_valid <= 1'b0;
      out_valid  <= 1'b0;
      out_data   <= 64'd0;
`ifdef MEMORY_LOAD_MISALIGN_CHECK_EN
      out_fault  <= 1'b0;
`endif
    end else begin
      dreq_valid <= (state_next == WAIT);
      out_valid  <= (state_next == RESP);
      if (state == IDLE && req_valid) begin
        mode_q    <= req_mode;
        off_q     <= req_addr[2:0];
        dreq_addr <= {req_addr[63:3], 3'b000};
        dreq_size <= req_supported ? load_msize(load_mode_t'(req_mode)) : MSIZE1;
        out_data  <= 64'd0;
`ifdef MEMORY_LOAD_MISALIGN_CHECK_EN
        out_fault <= req_fault;
`endif
      end else if (state == WAIT && dresp_data_ok) begin
        out_data <= extracted;
      end
    end
  end

endmodule

// File: tb/tb_memory_load_unit.sv
// tb/tb_memory_load_unit.sv - self-checking bench for memory_load_unit; honours MEMORY_LOAD_MISALIGN_CHECK_EN
module tb_memory_load_unit;
  import common::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [63:0] req_addr;
  logic [3:0]  req_mode;
  logic        dreq_valid;
  logic [63:0] dreq_addr;
  msize_t      dreq_size;
  logic [7:0]  dreq_strobe;
  logic        dresp_addr_ok;
  logic        dresp_data_ok;
  logic [63:0] dresp_data;
  logic        out_valid;
  logic [63:0] out_data;
  logic        out_ready;
`ifdef MEMORY_LOAD_MISALIGN_CHECK_EN
  logic        out_fault;
`endif

  int vectors = 0;
  int miscompares = 0;

  localparam logic [63:0] D = 64'hF0E0D0C0B0A09080;

  always #5 clk = ~clk;

  memory_load_unit dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_addr      (req_addr),
    .req_mode      (req_mode),
    .dreq_valid    (dreq_valid),
    .dreq_addr     (dreq_addr),
    .dreq_size     (dreq_size),
    .dreq_strobe   (dreq_strobe),
    .dresp_addr_ok (dresp_addr_ok),
    .dresp_data_ok (dresp_data_ok),
    .dresp_data    (dresp_data),
    .out_valid     (out_valid),
    .out_data      (out_data),
`ifdef MEMORY_LOAD_MISALIGN_CHECK_EN
    .out_fault     (out_fault),
`endif
    .out_ready     (out_ready)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
    end
  endtask

  // Reference load: gather bytes one at a time, then extend by the mode's width.
  function automatic logic [63:0] ref_load(input logic [63:0] data, input logic [63:0] addr,
                                           input logic [3:0] mode);
    int n;
    bit sgn;
    int off;
    logic [63:0] res;
    case (mode)
      4'd0: begin n = 1; sgn = 1; end
      4'd1: begin n = 2; sgn = 1; end
      4'd2: begin n = 4; sgn = 1; end
      4'd3: begin n = 8; sgn = 0; end
      4'd4: begin n = 1; sgn = 0; end
      4'd5: begin n = 2; sgn = 0; end
      4'd6: begin n = 4; sgn = 0; end
      default: return 64'd0;
    endcase
    off = int'(addr % 8);
    res = 64'd0;
    for (int i = 0; i < n; i++)
      if (off + i < 8) res = res | (((data >> (8 * (off + i))) & 64'hFF) << (8 * i));
    if (sgn && n < 8 && res[8 * n - 1]) res = res | ~((64'd1 << (8 * n)) - 64'd1);
    return res;
  endfunction

  function automatic logic [63:0] ref_size(input logic [3:0] mode);
    case (mode)
      4'd0, 4'd4: return 64'(MSIZE1);
      4'd1, 4'd5: return 64'(MSIZE2);
      4'd2, 4'd6: return 64'(MSIZE4);
      default:    return 64'(MSIZE8);
    endcase
  endfunction

  function automatic bit ref_fault(input logic [63:0] addr, input logic [3:0] mode);
`ifdef MEMORY_LOAD_MISALIGN_CHECK_EN
    case (mode)
      4'd1, 4'd5: return (addr % 2) != 0;
      4'd2, 4'd6: return (addr % 4) != 0;
      4'd3:       return (addr % 8) != 0;
      default:    return 1'b0;
    endcase
`else
    return 1'b0;
`endif
  endfunction

  // One complete load: request, optional bus stall, result with backpressure, return to IDLE.
  task automatic run_load(input logic [63:0] addr, input logic [3:0] mode, input logic [63:0] data,
                          input int stall, input int hold, input logic [63:0] exp_data);
    int  waitc;
    bit  bus;
    bit  flt;
    waitc = 0;
    flt = ref_fault(addr, mode);
    bus = (mode <= 4'd6) && !flt;
    @(negedge clk);
    while (!req_ready && waitc < 20) begin
      @(negedge clk);
      waitc++;
    end
    chk("req_ready_idle", 64'(req_ready), 64'd1);
    req_valid = 1'b1;
    req_addr  = addr;
    req_mode  = mode;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_addr  = {$urandom, $urandom};
    req_mode  = 4'($urandom);
    @(negedge clk);
    if (bus) begin
      chk("dreq_valid_c1", 64'(dreq_valid), 64'd1);
      chk("dreq_addr", dreq_addr, {addr[63:3], 3'b000});
      chk("dreq_size", 64'(dreq_size), ref_size(mode));
      chk("dreq_strobe", 64'(dreq_strobe), 64'd0);
      chk("req_ready_busy", 64'(req_ready), 64'd0);
      for (int i = 0; i < stall; i++) begin
        dresp_addr_ok = (i == 0);
        dresp_data    = {$urandom, $urandom};
        @(negedge clk);
        dresp_addr_ok = 1'b0;
        chk("stall_dreq_valid", 64'(dreq_valid), 64'd1);
        chk("stall_dreq_addr", dreq_addr, {addr[63:3], 3'b000});
        chk("stall_out_valid", 64'(out_valid), 64'd0);
      end
      dresp_addr_ok = (stall == 0);
      dresp_data_ok = 1'b1;
      dresp_data    = data;
      @(posedge clk);
      #1;
      dresp_addr_ok = 1'b0;
      dresp_data_ok = 1'b0;
      dresp_data    = {$urandom, $urandom};
      @(negedge clk);
      chk("out_valid_n1", 64'(out_valid), 64'd1);
      chk("out_data", out_data, exp_data);
      chk("dreq_valid_resp", 64'(dreq_valid), 64'd0);
    end else begin
      chk("nobus_out_valid_c1", 64'(out_valid), 64'd1);
      chk("nobus_out_data", out_data, 64'd0);
      chk("nobus_dreq_valid", 64'(dreq_valid), 64'd0);
    end
`ifdef MEMORY_LOAD_MISALIGN_CHECK_EN
    chk("out_fault", 64'(out_fault), 64'(flt));
`endif
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_out_valid", 64'(out_valid), 64'd1);
      chk("hold_out_data", out_data, bus ? exp_data : 64'd0);
      chk("hold_req_ready", 64'(req_ready), 64'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    chk("idle_out_valid", 64'(out_valid), 64'd0);
    chk("idle_req_ready", 64'(req_ready), 64'd1);
  endtask

  initial begin
    logic [63:0] a;
    logic [63:0] d;
    logic [3:0]  m;
    reset = 1'b0;
    req_valid = 1'b0;
    req_addr = 64'd0;
    req_mode = 4'd0;
    dresp_addr_ok = 1'b0;
    dresp_data_ok = 1'b0;
    dresp_data = 64'd0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_dreq_valid", 64'(dreq_valid), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", out_data, 64'd0);
    chk("rst_dreq_addr", dreq_addr, 64'd0);
    reset = 1'b1;

    run_load(64'h1003, 4'd0, D, 0, 0, 64'hFFFFFFFFFFFFFFB0);
    run_load(64'h1003, 4'd4, D, 1, 0, 64'h00000000000000B0);
    run_load(64'h1006, 4'd1, D, 0, 0, 64'hFFFFFFFFFFFFF0E0);
    run_load(64'h1006, 4'd5, D, 0, 0, 64'h000000000000F0E0);
    run_load(64'h1004, 4'd6, D, 0, 0, 64'h00000000F0E0D0C0);
    run_load(64'h1000, 4'd2, D, 0, 0, 64'hFFFFFFFFB0A09080);
    run_load(64'h1000, 4'd3, D, 0, 0, D);
    run_load(64'h2000, 4'd3, D, 5, 0, D);
    run_load(64'h1000, 4'd2, D, 2, 3, 64'hFFFFFFFFB0A09080);
    run_load(64'h1000, 4'd7, D, 0, 1, 64'd0);
    run_load(64'h1001, 4'd1, D, 0, 0, ref_load(D, 64'h1001, 4'd1));

    // Reset during WAIT drops the bus request; a later data_ok must not produce a result.
    @(negedge clk);
    req_valid = 1'b1;
    req_addr  = 64'h3008;
    req_mode  = 4'd3;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("mid_dreq_valid", 64'(dreq_valid), 64'd1);
    reset = 1'b0;
    #1;
    chk("mid_rst_dreq_valid", 64'(dreq_valid), 64'd0);
    chk("mid_rst_req_ready", 64'(req_ready), 64'd0);
    chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    dresp_data_ok = 1'b1;
    dresp_data = D;
    @(posedge clk);
    #1;
    dresp_data_ok = 1'b0;
    @(negedge clk);
    chk("late_data_ok_out_valid", 64'(out_valid), 64'd0);
    chk("late_data_ok_req_ready", 64'(req_ready), 64'd1);
    chk("late_data_ok_out_data", out_data, 64'd0);

    for (int k = 0; k < 40; k++) begin
      a = {$urandom, $urandom};
      d = {$urandom, $urandom};
      m = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 6));
      run_load(a, m, d, int'($urandom_range(0, 4)), int'($urandom_range(0, 3)), ref_load(d, a, m));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
